// File: rtl/chunked_addsub_nbit_if.sv
// Operand/result bundle for the chunked add/sub unit: start/ready request side, done-qualified result side.
// No storage of its own; the unit samples operands on accept and holds results until the next accept.
// Backpressure: ready low while the unit is busy; start is ignored until ready returns.
interface chunked_addsub_nbit_if #(
    parameter int N = 32
);
    logic         start;
    logic         ready;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         done;

    modport master (
        output start, sub, a, b, cin,
        input  ready, s, cout, ovf, done
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, s, cout, ovf, done
    );
endinterface

// File: rtl/chunked_addsub_nbit.sv
// N-bit adder/subtractor processing W bits per clock through one W-bit slice and a registered carry.
// Latency: done pulses K = N/W edges after the accept edge; back-to-back accept in DONE adds no bubble.
// Backpressure: ready low throughout BUSY; start while busy is dropped, not queued.
module chunked_addsub_nbit #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    chunked_addsub_nbit_if.slave   io
);
    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  s_r;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          cout_r;
    logic          ovf_r;

    logic          accept;
    logic [W:0]    chunk_sum;
    logic          top_cin;
    logic [N-1:0]  a_nxt;
    logic [N-1:0]  b_nxt;
    logic [N-1:0]  s_nxt;

    assign io.ready = (state != BUSY);
    assign io.done  = (state == DONE);
    assign io.s     = s_r;
    assign io.cout  = cout_r;
    assign io.ovf   = ovf_r;

    assign accept = io.start & io.ready;

    // Operands shift right each chunk so the slice always reads the low W bits.
    assign chunk_sum = {1'b0, a_r[W-1:0]} + {1'b0, b_r[W-1:0]} + {{W{1'b0}}, carry};
    // On the last chunk the low bits are the top chunk, so this recovers the carry into bit N-1.
    assign top_cin   = a_r[W-1] ^ b_r[W-1] ^ chunk_sum[W-1];

    generate
        if (K == 1) begin : g_single
            assign a_nxt = a_r;
            assign b_nxt = b_r;
            assign s_nxt = chunk_sum[W-1:0];
        end else begin : g_multi
            assign a_nxt = {{W{1'b0}}, a_r[N-1:W]};
            assign b_nxt = {{W{1'b0}}, b_r[N-1:W]};
            // Result chunks enter at the top; after K chunks chunk 0 has reached bit 0.
            assign s_nxt = {chunk_sum[W-1:0], s_r[N-1:W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            state <= BUSY;
            a_r   <= io.a;
            b_r   <= io.sub ? ~io.b : io.b;
            carry <= io.sub ? 1'b1 : io.cin;
            cnt   <= '0;
            s_r   <= '0;
        end else begin
            case (state)
                BUSY: begin
                    a_r   <= a_nxt;
                    b_r   <= b_nxt;
                    s_r   <= s_nxt;
                    carry <= chunk_sum[W];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout_r <= chunk_sum[W];
                        ovf_r  <= top_cin ^ chunk_sum[W];
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_addsub_nbit.sv
// Bench for chunked_addsub_nbit: scoreboard of expected results fed by the stimulus, drained by a done monitor.
// Covers directed corner vectors, random ops, back-to-back accept, mid-operation reset and the K=1 build.
module tb_chunked_addsub_nbit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t last_exp;
    exp_t mon_e;

    chunked_addsub_nbit_if #(.N(32)) io ();
    chunked_addsub_nbit_if #(.N(16)) io16 ();

    chunked_addsub_nbit #(.N(32), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    chunked_addsub_nbit #(.N(16), .W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .io  (io16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain wide arithmetic on n-bit operands.
    function automatic exp_t model(input int n, input logic sb, input logic [31:0] aa,
                                   input logic [31:0] bb, input logic ci);
        exp_t        r;
        logic [63:0] mask, av, be, full;
        mask   = (64'd1 << n) - 64'd1;
        av     = {32'h0, aa} & mask;
        be     = (sb ? ~{32'h0, bb} : {32'h0, bb}) & mask;
        full   = av + be + {63'h0, (sb ? 1'b1 : ci)};
        r.s    = 32'(full & mask);
        r.cout = full[n];
        r.ovf  = (av[n-1] == be[n-1]) && (full[n-1] != av[n-1]);
        r.acc  = 0;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && io.done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", {63'h0, io.done}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("s",             {32'h0, io.s}, {32'h0, mon_e.s});
                chk("cout",          {63'h0, io.cout}, {63'h0, mon_e.cout});
                chk("ovf",           {63'h0, io.ovf}, {63'h0, mon_e.ovf});
                chk("latency",       64'(cyc), 64'(mon_e.acc + 4));
                chk("ready_in_done", {63'h0, io.ready}, 64'd1);
            end
        end
    end

    task automatic issue(input logic sb, input logic [31:0] aa, input logic [31:0] bb,
                         input logic ci, output int acc);
        int guard;
        @(negedge clk);
        io.start = 1'b1;
        io.sub   = sb;
        io.a     = aa;
        io.b     = bb;
        io.cin   = ci;
        guard    = 0;
        while (!io.ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!io.ready) begin
            chk("accept_timeout", {63'h0, io.ready}, 64'd1);
            acc = -1;
        end else begin
            last_exp     = model(32, sb, aa, bb, ci);
            last_exp.acc = cyc + 1;
            sbq.push_back(last_exp);
            acc = cyc + 1;
        end
        @(negedge clk);
        io.start = 1'b0;
        io.a     = $urandom;
        io.b     = $urandom;
        io.sub   = 1'($urandom);
        io.cin   = 1'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic k1(input logic sb, input logic [15:0] aa, input logic [15:0] bb, input logic ci);
        exp_t e;
        @(negedge clk);
        io16.start = 1'b1;
        io16.sub   = sb;
        io16.a     = aa;
        io16.b     = bb;
        io16.cin   = ci;
        chk("k1_ready", {63'h0, io16.ready}, 64'd1);
        @(negedge clk);
        io16.start = 1'b0;
        io16.a     = 16'($urandom);
        io16.b     = 16'($urandom);
        chk("k1_done_early", {63'h0, io16.done}, 64'd0);
        chk("k1_busy_ready", {63'h0, io16.ready}, 64'd0);
        @(negedge clk);
        e = model(16, sb, {16'h0, aa}, {16'h0, bb}, ci);
        chk("k1_done", {63'h0, io16.done}, 64'd1);
        chk("k1_s",    {48'h0, io16.s}, {32'h0, e.s});
        chk("k1_cout", {63'h0, io16.cout}, {63'h0, e.cout});
        chk("k1_ovf",  {63'h0, io16.ovf}, {63'h0, e.ovf});
    endtask

    initial begin
        int acc1, acc2, acc;
        io.start = 1'b0; io.sub = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0;
        io16.start = 1'b0; io16.sub = 1'b0; io16.a = '0; io16.b = '0; io16.cin = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {63'h0, io.ready}, 64'd1);
        chk("rst_done",  {63'h0, io.done}, 64'd0);
        chk("rst_s",     {32'h0, io.s}, 64'd0);
        chk("rst_cout",  {63'h0, io.cout}, 64'd0);
        chk("rst_ovf",   {63'h0, io.ovf}, 64'd0);

        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
        issue(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, acc);
        issue(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, acc);
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, acc);
        issue(1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b1, acc);
        drain();

        // start held high from BUSY into DONE: second op must land on the DONE edge.
        issue(1'b0, 32'h1234_5678, 32'h8765_4321, 1'b1, acc1);
        issue(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, acc2);
        chk("b2b_accept", 64'(acc2), 64'(acc1 + 5));
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), pick(), pick(), 1'($urandom), acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        repeat (3) @(negedge clk);
        chk("hold_s",    {32'h0, io.s}, {32'h0, last_exp.s});
        chk("hold_cout", {63'h0, io.cout}, {63'h0, last_exp.cout});
        chk("hold_ovf",  {63'h0, io.ovf}, {63'h0, last_exp.ovf});

        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
        drain();

        // Reset lands on the second BUSY edge; the op must never report done.
        @(negedge clk);
        io.start = 1'b1; io.sub = 1'b0; io.cin = 1'b0;
        io.a = 32'h1111_1111; io.b = 32'h2222_2222;
        chk("rst_pre_ready", {63'h0, io.ready}, 64'd1);
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {63'h0, io.ready}, 64'd1);
        chk("midrst_done",  {63'h0, io.done}, 64'd0);
        chk("midrst_s",     {32'h0, io.s}, 64'd0);
        chk("midrst_cout",  {63'h0, io.cout}, 64'd0);
        repeat (8) @(negedge clk);

        k1(1'b0, 16'h8000, 16'h8000, 1'b0);
        k1(1'b1, 16'h0003, 16'h0004, 1'b0);
        for (int i = 0; i < 6; i++) begin
            k1(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
